// File: rtl/rv32im_regfile_ras.sv
// ============================================================================
// rv32im_regfile_ras : integer register file with clear sequencer and RAS
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32im_regfile_ras #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int RAS_BITS = 3,
  parameter int BYPASS   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                write_i,
  input  logic [REG_BITS-1:0] rd_addr_i,
  input  logic [XLEN-1:0]     data_i,
  input  logic [REG_BITS-1:0] rs1_addr_i,
  input  logic [REG_BITS-1:0] rs2_addr_i,
  output logic [XLEN-1:0]     rs1_o,
  output logic [XLEN-1:0]     rs2_o,
  output logic                busy_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                push_ras_i,
  input  logic                pop_ras_i,
  output logic [XLEN-1:0]     ras_o,
  output logic [RAS_BITS:0]   ras_count_o,
  output logic                ras_overflow_o,
  output logic                ras_underflow_o
);

  localparam int NREGS     = 2**REG_BITS;
  localparam int RAS_DEPTH = 2**RAS_BITS;
  localparam logic [RAS_BITS:0] RAS_FULL = {1'b1, {RAS_BITS{1'b0}}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [REG_BITS-1:0] clear_idx, clear_idx_d;
  logic                busy;

  logic [XLEN-1:0]     regs [NREGS];
  logic                wr_en;
  logic [XLEN-1:0]     rs1_d, rs2_d;

  logic [XLEN-1:0]     ras_mem [RAS_DEPTH];
  logic [RAS_BITS-1:0] ras_top;
  logic [RAS_BITS-1:0] ras_top_inc;
  logic [RAS_BITS:0]   ras_count;
  logic                ras_full, ras_empty;
  logic [XLEN-1:0]     ret_addr;

  // Clear sequencer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_CLEAR;
      clear_idx <= '0;
    end else begin
      state     <= state_d;
      clear_idx <= clear_idx_d;
    end
  end

  always_comb begin
    state_d     = state;
    clear_idx_d = clear_idx;
    busy        = 1'b0;
    case (state)
      S_CLEAR: begin
        busy        = 1'b1;
        clear_idx_d = clear_idx + 1'b1;
        if (&clear_idx) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_CLEAR;
    endcase
  end

  assign busy_o = busy;

  // Register array
  assign wr_en = write_i && !busy && !rst_i && (rd_addr_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy)       regs[clear_idx] <= '0;
      else if (wr_en) regs[rd_addr_i] <= data_i;
    end
  end

  // Read ports; x0 is hardwired to zero regardless of array contents
  always_comb begin
    rs1_d = regs[rs1_addr_i];
    rs2_d = regs[rs2_addr_i];
    if (rs1_addr_i == '0) rs1_d = '0;
    else if ((BYPASS != 0) && wr_en && (rd_addr_i == rs1_addr_i)) rs1_d = data_i;
    if (rs2_addr_i == '0) rs2_d = '0;
    else if ((BYPASS != 0) && wr_en && (rd_addr_i == rs2_addr_i)) rs2_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs1_o <= '0;
      rs2_o <= '0;
    end else begin
      rs1_o <= rs1_d;
      rs2_o <= rs2_d;
    end
  end

  // Return-address stack
  assign ras_full    = (ras_count == RAS_FULL);
  assign ras_empty   = (ras_count == '0);
  assign ras_top_inc = ras_top + 1'b1;
  assign ret_addr    = pc_i + XLEN'(4);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_top         <= '0;
      ras_count       <= '0;
      ras_overflow_o  <= 1'b0;
      ras_underflow_o <= 1'b0;
    end else if (push_ras_i && pop_ras_i && !ras_empty) begin
      ras_mem[ras_top] <= ret_addr;
    end else if (push_ras_i) begin
      // Empty push+pop also lands here: it behaves as a plain push
      ras_top              <= ras_top_inc;
      ras_mem[ras_top_inc] <= ret_addr;
      if (ras_full) ras_overflow_o <= 1'b1;
      else          ras_count      <= ras_count + 1'b1;
    end else if (pop_ras_i) begin
      if (ras_empty) begin
        ras_underflow_o <= 1'b1;
      end else begin
        ras_top   <= ras_top - 1'b1;
        ras_count <= ras_count - 1'b1;
      end
    end
  end

  assign ras_o       = ras_empty ? '0 : ras_mem[ras_top];
  assign ras_count_o = ras_count;

endmodule

`default_nettype wire

// File: tb/tb_rv32im_regfile_ras.sv
// ============================================================================
// tb_rv32im_regfile_ras : directed self-checking bench for rv32im_regfile_ras
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32im_regfile_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] data, pc;
  logic        push, pop;

  logic [31:0] rs1, rs2, ras;
  logic        busy, ovf, unf;
  logic [3:0]  ras_count;

  logic [31:0] nb_rs1, nb_rs2, nb_ras;
  logic        nb_busy, nb_ovf, nb_unf;
  logic [3:0]  nb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32im_regfile_ras #(.XLEN(32), .REG_BITS(5), .RAS_BITS(3), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .write_i(write), .rd_addr_i(rd_addr), .data_i(data),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_o(rs1), .rs2_o(rs2),
    .busy_o(busy), .pc_i(pc), .push_ras_i(push), .pop_ras_i(pop), .ras_o(ras),
    .ras_count_o(ras_count), .ras_overflow_o(ovf), .ras_underflow_o(unf)
  );

  rv32im_regfile_ras #(.XLEN(32), .REG_BITS(5), .RAS_BITS(3), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .write_i(write), .rd_addr_i(rd_addr), .data_i(data),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_o(nb_rs1), .rs2_o(nb_rs2),
    .busy_o(nb_busy), .pc_i(pc), .push_ras_i(push), .pop_ras_i(pop), .ras_o(nb_ras),
    .ras_count_o(nb_count), .ras_overflow_o(nb_ovf), .ras_underflow_o(nb_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops, bounded so a stuck sequencer cannot hang the run
  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    write = 1'b1; rd_addr = a; data = d;
    tick();
    write = 1'b0;
  endtask

  task automatic read_regs(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1; rs2_addr = a2;
    tick();
  endtask

  task automatic ras_op(input logic ps, input logic pp, input logic [31:0] p);
    push = ps; pop = pp; pc = p;
    tick();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      read_regs(5'(i), 5'(32 - i));
      if (rs1 !== 32'h0 || rs2 !== 32'h0) bad++;
    end
    check(tag, 32'(bad), 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1; write = 1'b0; rd_addr = '0; data = '0;
    rs1_addr = '0; rs2_addr = '0; pc = '0; push = 1'b0; pop = 1'b0;

    tick();
    check("reset_rs1", rs1, 32'h0);
    check("reset_rs2", rs2, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h1);
    check("reset_ras", ras, 32'h0);
    check("reset_count", {28'h0, ras_count}, 32'h0);
    check("reset_flags", {30'h0, ovf, unf}, 32'h0);
    rst = 1'b0;
    wait_clear(n);
    check("busy_len", 32'(n), 32'd32);
    check_all_zero("clear_zero_initial");

    write_reg(5'd5, 32'hDEADBEEF);
    read_regs(5'd5, 5'd0);
    check("rd_x5", rs1, 32'hDEADBEEF);
    check("rd_x0", rs2, 32'h0);
    write_reg(5'd0, 32'h00001234);
    read_regs(5'd0, 5'd5);
    check("x0_ignored", rs1, 32'h0);
    check("x5_port2", rs2, 32'hDEADBEEF);

    write_reg(5'd7, 32'h00000011);
    write = 1'b1; rd_addr = 5'd7; data = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd7;
    tick();
    write = 1'b0;
    check("bypass_rs1", rs1, 32'hA5A5A5A5);
    check("bypass_rs2", rs2, 32'hA5A5A5A5);
    check("nobypass_rs1", nb_rs1, 32'h00000011);
    read_regs(5'd7, 5'd5);
    check("after_bypass", nb_rs1, 32'hA5A5A5A5);
    write_reg(5'd31, 32'hFFFFFFFF);
    read_regs(5'd31, 5'd7);
    check("rd_x31", rs1, 32'hFFFFFFFF);
    check("rd_x7", rs2, 32'hA5A5A5A5);

    // Restart the clear at index 10, with writes hammering during busy
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    write = 1'b1; rd_addr = 5'd5; data = 32'h0BADF00D;
    wait_clear(n);
    write = 1'b0;
    check("busy_len_restart", 32'(n), 32'd32);
    check_all_zero("clear_zero_after_restart");

    for (int k = 1; k <= 9; k++) begin
      ras_op(1'b1, 1'b0, 32'(k) * 32'h100);
      if (k == 8) begin
        check("ras_full_count", {28'h0, ras_count}, 32'd8);
        check("ras_full_noovf", {31'h0, ovf}, 32'h0);
      end
    end
    check("ras_ovf_count", {28'h0, ras_count}, 32'd8);
    check("ras_ovf_flag", {31'h0, ovf}, 32'h1);
    check("ras_ovf_top", ras, 32'h00000904);
    for (int k = 1; k <= 8; k++) begin
      ras_op(1'b0, 1'b1, 32'h0);
      if (k == 1) check("ras_pop1_top", ras, 32'h00000804);
      if (k == 7) check("ras_pop7_top", ras, 32'h00000204);
    end
    check("ras_empty_count", {28'h0, ras_count}, 32'd0);
    check("ras_empty_top", ras, 32'h0);
    check("ras_no_unf", {31'h0, unf}, 32'h0);
    ras_op(1'b0, 1'b1, 32'h0);
    check("ras_unf_flag", {31'h0, unf}, 32'h1);
    check("ras_unf_count", {28'h0, ras_count}, 32'd0);
    check("ras_ovf_sticky", {31'h0, ovf}, 32'h1);

    rst = 1'b1; tick(); rst = 1'b0;
    check("ras_flags_cleared", {30'h0, ovf, unf}, 32'h0);
    ras_op(1'b1, 1'b0, 32'h40);
    check("ras_push40", ras, 32'h00000044);
    ras_op(1'b1, 1'b1, 32'h80);
    check("ras_replace_top", ras, 32'h00000084);
    check("ras_replace_count", {28'h0, ras_count}, 32'd1);
    ras_op(1'b0, 1'b1, 32'h0);
    ras_op(1'b1, 1'b1, 32'h10);
    check("ras_pp_empty_top", ras, 32'h00000014);
    check("ras_pp_empty_count", {28'h0, ras_count}, 32'd1);
    check("ras_pp_empty_unf", {31'h0, unf}, 32'h0);
    ras_op(1'b1, 1'b0, 32'hFFFFFFFC);
    check("ras_wrap_top", ras, 32'h0);
    check("ras_wrap_count", {28'h0, ras_count}, 32'd2);
    ras_op(1'b0, 1'b1, 32'h0);
    check("ras_after_pop", ras, 32'h00000014);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
